// File: rtl/div_n_tick_gen.sv
// rtl/div_n_tick_gen.sv - rate-selectable clock divider with 1-cycle tick and square-wave output
module div_n_tick_gen #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned BASE_DIV = 312500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             tick,
  output logic             clk_out,
  output logic [SEL_W-1:0] sel_cur,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [63:0] MAX_DIV = 64'(BASE_DIV) << ((1 << SEL_W) - 1);

  generate
    if (BASE_DIV < 2) begin : g_bad_base
      $error("div_n_tick_gen: BASE_DIV must be at least 2");
    end
    if (CNT_W < 64) begin : g_width_chk
      if ((MAX_DIV >> CNT_W) != 64'd0) begin : g_bad_width
        $error("div_n_tick_gen: largest divisor does not fit in CNT_W");
      end
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             terminal;
  logic [CNT_W-1:0] div_sel;

  assign terminal = (cnt == div_cur - CNT_W'(1));
  assign div_sel  = CNT_W'(BASE_DIV) << sel;

  // sel is only ever applied at a period boundary or while parked at cnt==0,
  // so a running period is never shortened or stretched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      sel_cur <= '0;
      div_cur <= CNT_W'(BASE_DIV);
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (terminal) begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_out <= ~clk_out;
          sel_cur <= sel;
          div_cur <= div_sel;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (cnt == '0) begin
        sel_cur <= sel;
        div_cur <= div_sel;
      end
    end
  end

endmodule
